// File: rtl/fpga_cfg_bank_loader_if.sv
// Serial bitstream handshake between a bitstream source and the bank loader.
interface fpga_cfg_bank_loader_if;
  logic bs_valid;
  logic bs_data;
  logic bs_ready;

  modport master (output bs_valid, output bs_data, input  bs_ready);
  modport slave  (input  bs_valid, input  bs_data, output bs_ready);
endinterface

// File: rtl/fpga_cfg_bank_loader.sv
// Bank-style configuration loader: assembles BL_WIDTH-bit rows from a serial
// bitstream, drives them onto the bit lines and pulses one word line per row.
// Optional per-row even parity check: define CFG_LOADER_ROW_PARITY_EN.
module fpga_cfg_bank_loader #(
  parameter int BL_WIDTH = 514,
  parameter int WL_WIDTH = 407,
  parameter int WL_PULSE = 2
) (
  input  logic                              clk,
  input  logic                              global_resetn,
  input  logic                              start,
  fpga_cfg_bank_loader_if.slave             bs,
  output logic [0:BL_WIDTH-1]               bl,
  output logic [0:WL_WIDTH-1]               wl,
  output logic                              busy,
  output logic                              cfg_done,
  output logic                              cfg_error,
  output logic [$clog2(WL_WIDTH+1)-1:0]     row_count
);

  localparam int RC_W = $clog2(WL_WIDTH + 1);
  localparam int BC_W = (BL_WIDTH > 1) ? $clog2(BL_WIDTH) : 1;
  localparam int PC_W = $clog2(WL_PULSE + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE,
    ST_ERROR
`ifdef CFG_LOADER_ROW_PARITY_EN
    , ST_PARITY
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [PC_W-1:0]   r_pulse_cnt;
  logic              w_start;
  logic              w_shift_acc;
  logic              w_last_bit;
  logic              w_busy_next;
  logic              w_ready_next;
  logic [0:WL_WIDTH-1] w_wl_next;

  assign w_start     = start && (r_state == ST_IDLE || r_state == ST_DONE ||
                                 r_state == ST_ERROR);
  assign w_shift_acc = (r_state == ST_SHIFT) && bs.bs_valid && bs.bs_ready;
  assign w_last_bit  = (r_bit_cnt == BC_W'(BL_WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) r_state <= ST_IDLE;
    else                r_state <= w_next;
  end

  // Next-state logic plus the values the registered outputs take next cycle
  always_comb begin
    w_next       = r_state;
    w_busy_next  = 1'b0;
    w_ready_next = 1'b0;
    w_wl_next    = '0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) w_next = ST_SHIFT;
      ST_SHIFT: begin
        if (w_shift_acc && w_last_bit) begin
`ifdef CFG_LOADER_ROW_PARITY_EN
          w_next = ST_PARITY;
`else
          w_next = ST_SETUP;
`endif
        end
      end
`ifdef CFG_LOADER_ROW_PARITY_EN
      ST_PARITY: begin
        if (bs.bs_valid && bs.bs_ready)
          w_next = ((^bl) ^ bs.bs_data) ? ST_ERROR : ST_SETUP;
      end
`endif
      ST_SETUP: w_next = ST_PULSE;
      ST_PULSE: if (r_pulse_cnt == PC_W'(WL_PULSE - 1)) w_next = ST_HOLD;
      ST_HOLD:  w_next = ((row_count + RC_W'(1)) == RC_W'(WL_WIDTH)) ? ST_DONE
                                                                     : ST_SHIFT;
      default:  w_next = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it
    case (w_next)
      ST_SHIFT: begin w_busy_next = 1'b1; w_ready_next = 1'b1; end
`ifdef CFG_LOADER_ROW_PARITY_EN
      ST_PARITY: begin w_busy_next = 1'b1; w_ready_next = 1'b1; end
`endif
      ST_SETUP, ST_PULSE, ST_HOLD: w_busy_next = 1'b1;
      default: ;
    endcase
    for (int unsigned i = 0; i < WL_WIDTH; i++)
      w_wl_next[i] = (w_next == ST_PULSE) && (row_count == RC_W'(i));
  end

  // Row assembly, pulse timing, row counting and registered outputs
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      r_bit_cnt    <= '0;
      r_pulse_cnt  <= '0;
      bl           <= '0;
      wl           <= '0;
      busy         <= 1'b0;
      cfg_done     <= 1'b0;
      row_count    <= '0;
      bs.bs_ready  <= 1'b0;
    end else begin
      if (w_start) begin
        row_count <= '0;
        cfg_done  <= 1'b0;
        r_bit_cnt <= '0;
      end
      if (w_shift_acc) begin
        bl[r_bit_cnt] <= bs.bs_data;
        r_bit_cnt     <= w_last_bit ? '0 : r_bit_cnt + BC_W'(1);
      end
      r_pulse_cnt <= (r_state == ST_PULSE) ? r_pulse_cnt + PC_W'(1) : '0;
      if (r_state == ST_HOLD) row_count <= row_count + RC_W'(1);
      if (r_state == ST_HOLD && w_next == ST_DONE) cfg_done <= 1'b1;
      busy        <= w_busy_next;
      bs.bs_ready <= w_ready_next;
      wl          <= w_wl_next;
    end
  end

`ifdef CFG_LOADER_ROW_PARITY_EN
  // Sticky parity error, cleared by a fresh start
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn)                                cfg_error <= 1'b0;
    else if (w_start)                                  cfg_error <= 1'b0;
    else if (r_state == ST_PARITY && w_next == ST_ERROR) cfg_error <= 1'b1;
  end
`else
  assign cfg_error = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_bank_loader.sv
// Directed bench for fpga_cfg_bank_loader (BL=8, WL=4, WL_PULSE=2).
module tb_fpga_cfg_bank_loader;
  localparam int BL = 8;
  localparam int WL = 4;
  localparam int WP = 2;
`ifdef CFG_LOADER_ROW_PARITY_EN
  localparam int BPR     = BL + 1;
  localparam int ROW_CYC = BL + 3 + WP;
`else
  localparam int BPR     = BL;
  localparam int ROW_CYC = BL + 2 + WP;
`endif

  logic          clk = 1'b0;
  logic          global_resetn = 1'b0;
  logic          start = 1'b0;
  logic [0:BL-1] bl;
  logic [0:WL-1] wl;
  logic          busy, cfg_done, cfg_error;
  logic [2:0]    row_count;

  fpga_cfg_bank_loader_if bs_if ();

  fpga_cfg_bank_loader #(.BL_WIDTH(BL), .WL_WIDTH(WL), .WL_PULSE(WP)) u_dut (
    .clk          (clk),
    .global_resetn(global_resetn),
    .start        (start),
    .bs           (bs_if),
    .bl           (bl),
    .wl           (wl),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .cfg_error    (cfg_error),
    .row_count    (row_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] rows [4];
  logic       par  [4];

  int wl_cnt [4];
  int bl_err, onehot_err, stall_wl_err, done_cycle, min_gap;
  int order_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    bs_if.bs_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // Streams n_rows rows (plus parity bits when enabled) and records what the
  // word lines did; stops on cfg_done/cfg_error or after budget cycles.
  task automatic stream_rows(input int n_rows, input int stall_at, input int stall_len,
                             input int start_at, input int budget);
    int ptr, rem, gap, r, k, idx, ones;
    logic acc, in_stall;
    logic [0:WL-1] prev;
    ptr = 0; rem = stall_len; gap = 0; prev = '0;
    bl_err = 0; onehot_err = 0; stall_wl_err = 0; done_cycle = -1; min_gap = 1000;
    order_q.delete();
    for (int i = 0; i < 4; i++) wl_cnt[i] = 0;
    for (int c = 1; c <= budget; c++) begin
      in_stall = 1'b0;
      if (ptr == stall_at && rem > 0) begin
        bs_if.bs_valid = 1'b0; rem--; in_stall = 1'b1;
      end else if (ptr < n_rows * BPR) begin
        r = ptr / BPR; k = ptr % BPR;
        bs_if.bs_valid = 1'b1;
        bs_if.bs_data  = (k < BL) ? rows[r][k] : par[r];
      end else begin
        bs_if.bs_valid = 1'b0;
      end
      start = (c == start_at);
      acc = bs_if.bs_valid && bs_if.bs_ready;
      tick();
      start = 1'b0;
      if (acc) ptr++;
      if (in_stall && wl != '0) stall_wl_err++;
      if (wl != '0) begin
        idx = 0; ones = 0;
        for (int i = 0; i < WL; i++) if (wl[i]) begin idx = i; ones++; end
        if (ones != 1) onehot_err++;
        wl_cnt[idx]++;
        for (int b = 0; b < BL; b++) if (bl[b] !== rows[idx][b]) bl_err++;
        if (prev == '0) begin
          if (order_q.size() > 0 && gap < min_gap) min_gap = gap;
          order_q.push_back(idx);
        end
        gap = 0;
      end else begin
        gap++;
      end
      prev = wl;
      if (cfg_done || cfg_error) begin done_cycle = c; break; end
    end
    bs_if.bs_valid = 1'b0;
  endtask

  task automatic set_default_rows();
    rows[0] = 8'h55; rows[1] = 8'hAA; rows[2] = 8'h0F; rows[3] = 8'hF0;
    for (int i = 0; i < 4; i++) par[i] = 1'b0;
  endtask

  task automatic test_reset();
    global_resetn = 1'b0; bs_if.bs_valid = 1'b1; bs_if.bs_data = 1'b1; start = 1'b0;
    #2;
    checks++; if (bs_if.bs_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bs_if.bs_ready); end
    checks++; if (bl !== '0) begin failures++; $display("FAIL rst_bl got=%h exp=0", bl); end
    checks++; if (wl !== '0) begin failures++; $display("FAIL rst_wl got=%h exp=0", wl); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", cfg_done); end
    checks++; if (cfg_error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", cfg_error); end
    checks++; if (row_count !== 3'd0) begin failures++; $display("FAIL rst_rowcnt got=%0d exp=0", row_count); end
    @(negedge clk); global_resetn = 1'b1;
    repeat (4) tick();
    checks++; if (bs_if.bs_ready !== 1'b0) begin failures++; $display("FAIL nostart_ready got=%b exp=0", bs_if.bs_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nostart_busy got=%b exp=0", busy); end
    bs_if.bs_valid = 1'b0;
  endtask

  task automatic test_full_load();
    set_default_rows();
    do_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", busy); end
    checks++; if (bs_if.bs_ready !== 1'b1) begin failures++; $display("FAIL start_ready got=%b exp=1", bs_if.bs_ready); end
    stream_rows(4, -1, 0, 0, 200);
    checks++; if (done_cycle !== WL * ROW_CYC) begin failures++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_cycle, WL * ROW_CYC); end
    for (int i = 0; i < WL; i++) begin
      checks++; if (wl_cnt[i] !== WP) begin failures++; $display("FAIL full_wl%0d_len got=%0d exp=%0d", i, wl_cnt[i], WP); end
    end
    checks++; if (bl_err !== 0) begin failures++; $display("FAIL full_bl_during_wl got=%0d exp=0", bl_err); end
    checks++; if (onehot_err !== 0) begin failures++; $display("FAIL full_wl_onehot got=%0d exp=0", onehot_err); end
    checks++; if (min_gap < 2) begin failures++; $display("FAIL full_wl_gap got=%0d exp>=2", min_gap); end
    checks++; if (row_count !== 3'd4) begin failures++; $display("FAIL full_rowcnt got=%0d exp=4", row_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy got=%b exp=0", busy); end
    checks++; if (cfg_error !== 1'b0) begin failures++; $display("FAIL full_error got=%b exp=0", cfg_error); end
    repeat (3) tick();
    checks++; if (cfg_done !== 1'b1) begin failures++; $display("FAIL done_sticky got=%b exp=1", cfg_done); end
    checks++; if (bs_if.bs_ready !== 1'b0) begin failures++; $display("FAIL done_ready got=%b exp=0", bs_if.bs_ready); end
  endtask

  task automatic test_stall();
    rows[0] = 8'h3C; rows[1] = 8'h96; rows[2] = 8'h81; rows[3] = 8'h7E;
    do_start();
    checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL restart_done_clr got=%b exp=0", cfg_done); end
    checks++; if (row_count !== 3'd0) begin failures++; $display("FAIL restart_rowcnt got=%0d exp=0", row_count); end
    stream_rows(4, BPR + 3, 5, 0, 200);
    checks++; if (done_cycle !== WL * ROW_CYC + 5) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=%0d", done_cycle, WL * ROW_CYC + 5); end
    checks++; if (stall_wl_err !== 0) begin failures++; $display("FAIL stall_wl got=%0d exp=0", stall_wl_err); end
    checks++; if (bl_err !== 0) begin failures++; $display("FAIL stall_bl got=%0d exp=0", bl_err); end
    checks++; if (wl_cnt[1] !== WP) begin failures++; $display("FAIL stall_wl1_len got=%0d exp=%0d", wl_cnt[1], WP); end
  endtask

  task automatic test_start_busy();
    set_default_rows();
    do_start();
    stream_rows(4, -1, 0, ROW_CYC + 3, 200);
    checks++; if (done_cycle !== WL * ROW_CYC) begin failures++; $display("FAIL busy_done_cycle got=%0d exp=%0d", done_cycle, WL * ROW_CYC); end
    checks++; if (order_q.size() !== WL) begin failures++; $display("FAIL busy_pulses got=%0d exp=%0d", order_q.size(), WL); end
    for (int i = 0; i < order_q.size(); i++) begin
      checks++; if (order_q[i] !== i) begin failures++; $display("FAIL busy_order%0d got=%0d exp=%0d", i, order_q[i], i); end
    end
    checks++; if (row_count !== 3'd4) begin failures++; $display("FAIL busy_rowcnt got=%0d exp=4", row_count); end
  endtask

  task automatic test_reset_mid_pulse();
    set_default_rows();
    do_start();
    stream_rows(4, -1, 0, 0, 2 * ROW_CYC + BPR + 1);
    checks++; if (wl !== 4'b0010) begin failures++; $display("FAIL midpulse_wl2 got=%b exp=0010", wl); end
    #2 global_resetn = 1'b0;
    #1;
    checks++; if (wl !== '0) begin failures++; $display("FAIL async_wl got=%b exp=0000", wl); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy got=%b exp=0", busy); end
    checks++; if (row_count !== 3'd0) begin failures++; $display("FAIL async_rowcnt got=%0d exp=0", row_count); end
    @(negedge clk); global_resetn = 1'b1;
    tick();
    do_start();
    stream_rows(4, -1, 0, 0, 200);
    checks++; if (order_q.size() == 0 || order_q[0] !== 0) begin failures++; $display("FAIL reload_first_row got=%0d exp=0", (order_q.size() == 0) ? -1 : order_q[0]); end
    checks++; if (done_cycle !== WL * ROW_CYC) begin failures++; $display("FAIL reload_done_cycle got=%0d exp=%0d", done_cycle, WL * ROW_CYC); end
    checks++; if (row_count !== 3'd4) begin failures++; $display("FAIL reload_rowcnt got=%0d exp=4", row_count); end
  endtask

`ifdef CFG_LOADER_ROW_PARITY_EN
  task automatic test_parity();
    rows[0] = 8'h03; par[0] = 1'b0;
    rows[1] = 8'h01; par[1] = 1'b0;
    do_start();
    stream_rows(2, -1, 0, 0, 100);
    checks++; if (cfg_error !== 1'b1) begin failures++; $display("FAIL par_error got=%b exp=1", cfg_error); end
    checks++; if (row_count !== 3'd1) begin failures++; $display("FAIL par_rowcnt got=%0d exp=1", row_count); end
    checks++; if (wl_cnt[0] !== WP) begin failures++; $display("FAIL par_wl0_len got=%0d exp=%0d", wl_cnt[0], WP); end
    checks++; if (wl_cnt[1] !== 0) begin failures++; $display("FAIL par_wl1_len got=%0d exp=0", wl_cnt[1]); end
    checks++; if (done_cycle !== ROW_CYC + BPR) begin failures++; $display("FAIL par_err_cycle got=%0d exp=%0d", done_cycle, ROW_CYC + BPR); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL par_busy got=%b exp=0", busy); end
  endtask
`endif

  initial begin
    bs_if.bs_valid = 1'b0;
    bs_if.bs_data  = 1'b0;
    test_reset();
    test_full_load();
    test_stall();
    test_start_busy();
    test_reset_mid_pulse();
`ifdef CFG_LOADER_ROW_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpga_cfg_bank_loader.md
# fpga_cfg_bank_loader

Configuration loader for one fabric config region (memory-bank style, bit-line/word-line addressed). It accepts the bitstream as a serial bit stream with a valid/ready handshake and assembles one row of `BL_WIDTH` bits at a time. It then drives the row onto the region's bit lines and pulses the row's word line, and repeats for all `WL_WIDTH` rows. It sits between the bitstream source (test harness or config port) and the `fpga_top` `bl_config_region_0` / `wl_config_region_0` inputs, replacing direct bitstream forcing.

## Interface
Parameters:
- `BL_WIDTH`, 514: bit lines per row.
- `WL_WIDTH`, 407: word lines (rows) in the region.
- `WL_PULSE`, 2: cycles each word line is held high; legal values ≥1.

Ports:
- `clk`  in  1  loader clock; all logic is rising-edge.
- `global_resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin loading; only honoured in IDLE, DONE or ERROR.
- `bs_valid`  in  1  bitstream bit valid.
- `bs_data`  in  1  bitstream bit.
- `bs_ready`  out  1  loader accepts a bit this cycle.
- `bl`  out  [0:BL_WIDTH-1]  bit-line drive.
- `wl`  out  [0:WL_WIDTH-1]  word-line drive; at most one bit high.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE or ERROR.
- `cfg_done`  out  1  all rows written; sticky.
- `cfg_error`  out  1  parity failure (macro only); sticky.
- `row_count`  out  $clog2(WL_WIDTH+1)  number of rows completed.

## Operation
- States: IDLE, SHIFT, SETUP, PULSE, HOLD, DONE, ERROR (plus PARITY with the macro).
- IDLE → SHIFT on `start`. Entering SHIFT from `start` clears `row_count`, `cfg_done` and `cfg_error`.
- SHIFT:
  - `bs_ready`=1; a bit is accepted when `bs_valid && bs_ready`.
  - The k-th accepted bit of a row (k=0..BL_WIDTH-1) appears on `bl[k]`.
  - `bl` may change freely during SHIFT because `wl` is all zero.
  - After bit BL_WIDTH-1 is accepted → SETUP.
- SETUP: 1 cycle, `bl` stable, `wl`=0, `bs_ready`=0.
- PULSE: `WL_PULSE` cycles with `wl[row_count]`=1 and `bl` stable.
- HOLD: 1 cycle, `wl`=0, `bl` stable. `row_count` increments at the end of HOLD.
  - If the new `row_count` equals WL_WIDTH → DONE.
  - Otherwise → SHIFT.
- DONE: `cfg_done`=1, `busy`=0, `bs_ready`=0. Stays until `start` (restart at row 0) or reset.
- `start` while busy is ignored.
- Gaps in `bs_valid` stall SHIFT indefinitely; no timeout.
- Reset at any point, including mid-row or mid-pulse: immediately forces IDLE and all outputs to reset values. `wl` drops asynchronously. The partial row is discarded.

## Timing
- Reset values: `bs_ready`=0, `bl`=0, `wl`=0, `busy`=0, `cfg_done`=0, `cfg_error`=0, `row_count`=0.
- All outputs are registered.
- `busy` and `bs_ready` rise 1 cycle after `start` is sampled.
- Per row with continuous `bs_valid`: BL_WIDTH + 2 + WL_PULSE cycles.
- `cfg_done` rises the cycle after the final HOLD.
- Full load without the macro: WL_WIDTH × (BL_WIDTH + 2 + WL_PULSE) cycles, plus 1 start cycle.
- Between consecutive rows, `wl` has at least 2 zero cycles (HOLD, then the first SHIFT cycle).

## Configuration
- Macro: `CFG_LOADER_ROW_PARITY_EN`.
- Defined:
  - Each row is followed by one parity bit, accepted in the PARITY state (`bs_ready`=1) between SHIFT and SETUP.
  - Parity is even: the XOR of the BL_WIDTH data bits and the parity bit must be 0.
  - On match → SETUP.
  - On mismatch → ERROR: no word line is pulsed, `cfg_error`=1, `busy`=0, `row_count` holds the index of the failing row. ERROR exits only on `start` or reset.
  - Per-row cost is 1 extra cycle.
- Undefined: there is no PARITY state, `cfg_error` is tied 0, and streams carry BL_WIDTH bits per row.

## Test plan
Bench parameters: BL_WIDTH=8, WL_WIDTH=4, WL_PULSE=2, unless stated.
- Reset check: assert `global_resetn`=0 → every output equals its reset value. Release, hold `bs_valid`=1 with no `start` → `bs_ready` stays 0.
- Full load:
  - Stimulus: `start`, then rows 0x55, 0xAA, 0x0F, 0xF0 streamed continuously, bit 0 first.
  - Each `wl[i]` is high for exactly 2 cycles while `bl` equals its row.
  - `cfg_done`=1 at cycle 1+4×12.
  - `row_count`=4.
- Stall handling: drop `bs_valid` for 5 cycles mid-row → row completes 5 cycles later with correct `bl`, and `wl` stays 0 during the stall.
- Reset mid-pulse: assert `global_resetn` low during PULSE of row 2 → `wl`=0 in the same cycle (asynchronous). After release and a fresh `start`, loading begins at row 0.
- Start while busy: pulse `start` during row 1 → no effect, and the row order and count are unchanged.
- With `CFG_LOADER_ROW_PARITY_EN`:
  - Row 0x03 with parity 0 → written.
  - Row 0x01 with parity 0 → `cfg_error`=1, `row_count`=1, and no `wl[1]` pulse.
